pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives write-enable and flush controls for the PC, the IF/ID register and the ID/EX register. Sources:
- load-use data hazards
- taken branches resolved in EX
- jumps resolved in ID
- data-memory busy freezes

Also keeps stall/flush event counters for performance debug.

Parameters:
- LU_STALL, 1, bubble cycles inserted per load-use hazard (1..7)
- CNT_W, 32, width of stall_cnt and flush_cnt

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ID_rs  in  5  rs field of instruction in ID
- ID_rt  in  5  rt field of instruction in ID
- ID_use_rs  in  1  ID instruction reads rs
- ID_use_rt  in  1  ID instruction reads rt
- ID_jump  in  1  ID holds j/jal/jr, target known in ID
- EX_memRead  in  1  EX holds a load
- EX_rd  in  5  destination of EX instruction
- EX_brTaken  in  1  branch in EX resolved taken
- dmem_busy  in  1  data memory not ready; whole pipe must freeze
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IFIDFlush  out  1  IF/ID loads zero (NOP); only effective with IFIDWrite=1
- IDEXFlush  out  1  ID/EX loads bubble
- pipeFreeze  out  1  holds ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  CNT_W  cycles with IFIDWrite=0
- flush_cnt  out  CNT_W  cycles with IFIDFlush=1

Behaviour:
- Reset is synchronous, active-high, on clk. Reset clears state to RUN, lu_cnt to 0, and both counters to 0.
- Outputs are combinational from state and inputs. Same-cycle response; latency 0.

Hazard definitions:
- luHaz = EX_memRead & EX_rd!=0 & ((ID_use_rs & ID_rs==EX_rd) | (ID_use_rt & ID_rt==EX_rd)).

States:
- RUN: normal operation.
- LU_WAIT: counting remaining load-use bubbles; lu_cnt holds the remaining count.
- MEM_WAIT: frozen on dmem_busy.

Output priority, highest first, evaluated every cycle:
1. dmem_busy=1:
   - PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXFlush=0, pipeFreeze=1.
   - Next state MEM_WAIT. lu_cnt is held.
2. EX_brTaken=1:
   - PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1.
   - Next state RUN, lu_cnt cleared. The branch kills any pending load-use stall.
3. state==LU_WAIT, or RUN with luHaz=1:
   - PCWrite=0, IFIDWrite=0, IDEXFlush=1.
   - On entry from RUN with LU_STALL>1: lu_cnt = LU_STALL-1, next state LU_WAIT.
   - In LU_WAIT: lu_cnt decrements; leave to RUN when lu_cnt reaches 1 and is consumed.
   - LU_STALL=1 never enters LU_WAIT.
4. ID_jump=1:
   - PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=0.
5. Otherwise:
   - PCWrite=1, IFIDWrite=1, all flushes 0, pipeFreeze=0.

Freeze and flush rules:
- MEM_WAIT exits to the pre-freeze state: LU_WAIT if lu_cnt!=0, else RUN. Re-evaluate the same cycle dmem_busy falls.
- IFIDFlush is asserted only with IFIDWrite=1. The IF/ID register gives write priority over flush, so a flush with write low would be lost.

Counters:
- Counters wrap at 2^CNT_W.
- stall_cnt increments when IFIDWrite=0, including freeze cycles.
- flush_cnt increments when IFIDFlush=1.

Reset mid-stall: reset forces RUN with lu_cnt=0 the next cycle; no residual bubble.

Decomposition:
- Shared pipeline package holds:
  - state enum {RUN, LU_WAIT, MEM_WAIT}
  - REG_ZERO=5'd0
  - NOP_INST=32'd0
- Sub-module hazard_cnt (CNT_W-bit wrapping enable counter with sync clear), instantiated twice. Everything else stays in the top module.

Test Plan:
- Load-use: EX_memRead=1, EX_rd=8, ID_rs=8, ID_use_rs=1, LU_STALL=1 -> exactly 1 cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; stall_cnt=1.
- LU_STALL=3, same hazard held one cycle -> 3 consecutive bubble cycles, then RUN; EX_rd=0 with same fields -> no stall.
- Branch during LU_WAIT: EX_brTaken=1 in 2nd bubble -> that cycle IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, next cycle RUN; flush_cnt=1.
- dmem_busy for 4 cycles mid-LU_WAIT with lu_cnt=2 -> pipeFreeze=1, all enables 0 for 4 cycles, then 2 remaining bubbles resume.
- ID_jump=1 together with EX_brTaken=1 -> branch response; ID_jump alone -> IFIDFlush=1, IDEXFlush=0, PCWrite=1.
- rst=1 during LU_WAIT -> next cycle state RUN, counters 0, PCWrite=1 absent hazards.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline types and constants
package pipe_hazard_ctrl_pkg;
    typedef enum logic [1:0] {RUN, LU_WAIT, MEM_WAIT} state_t;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INST = 32'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX hazard sources in, pipeline enables/flushes and perf counters out
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_use_rs;
    logic             ID_use_rt;
    logic             ID_jump;
    logic             EX_memRead;
    logic [4:0]       EX_rd;
    logic             EX_brTaken;
    logic             dmem_busy;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic             pipeFreeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_jump, EX_memRead, EX_rd, EX_brTaken, dmem_busy,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze, stall_cnt, flush_cnt
    );
    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_jump, EX_memRead, EX_rd, EX_brTaken, dmem_busy,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cnt.sv
// hazard_cnt: wrapping event counter with enable and synchronous clear
module hazard_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk)
        r_cnt <= rst ? '0 : r_cnt + {{(CNT_W-1){1'b0}}, i_en};
    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, branch, jump and dmem-busy hazards
// Outputs are combinational from state and inputs; counters track stall and flush cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL - 1);
    state_t     r_state, w_next, w_eff;
    logic [2:0] r_lu, w_lu_next;
    logic       w_lu_haz, w_pc, w_ifw, w_iff, w_idf, w_frz;
    assign w_lu_haz = hz.EX_memRead && hz.EX_rd != REG_ZERO &&
                      ((hz.ID_use_rs && hz.ID_rs == hz.EX_rd) || (hz.ID_use_rt && hz.ID_rt == hz.EX_rd));
    // leaving a freeze resumes whatever was pending, decided in the same cycle busy drops
    assign w_eff = (r_state == MEM_WAIT) ? ((r_lu != 3'd0) ? LU_WAIT : RUN) : r_state;
    always_comb begin
        w_pc      = 1'b1;
        w_ifw     = 1'b1;
        w_iff     = 1'b0;
        w_idf     = 1'b0;
        w_frz     = 1'b0;
        w_next    = RUN;
        w_lu_next = r_lu;
        if (hz.dmem_busy) begin
            w_pc   = 1'b0;
            w_ifw  = 1'b0;
            w_frz  = 1'b1;
            w_next = MEM_WAIT;
        end else if (hz.EX_brTaken) begin
            w_iff     = 1'b1;
            w_idf     = 1'b1;
            w_lu_next = 3'd0;
        end else if (w_eff == LU_WAIT || w_lu_haz) begin
            w_pc      = 1'b0;
            w_ifw     = 1'b0;
            w_idf     = 1'b1;
            w_lu_next = (w_eff == LU_WAIT) ? r_lu - 3'd1 : LU_RELOAD;
            w_next    = (w_lu_next != 3'd0) ? LU_WAIT : RUN;
        end else if (hz.ID_jump) begin
            w_iff = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? RUN : w_next;
        r_lu    <= rst ? 3'd0 : w_lu_next;
    end
    assign hz.PCWrite    = w_pc;
    assign hz.IFIDWrite  = w_ifw;
    assign hz.IFIDFlush  = w_iff;
    assign hz.IDEXFlush  = w_idf;
    assign hz.pipeFreeze = w_frz;
    hazard_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_en (~w_ifw),
        .o_cnt(hz.stall_cnt)
    );
    hazard_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_iff),
        .o_cnt(hz.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two instances (LU_STALL=1/32-bit, LU_STALL=3/4-bit) checked against a bubble-count model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic       mr, urs, urt, jmp, br, busy;
    logic [4:0] rd, rs, rt;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    pipe_hazard_ctrl_if #(.CNT_W(32)) ia ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  ib ();
    assign ia.ID_rs = rs;  assign ia.ID_rt = rt;  assign ia.ID_use_rs = urs; assign ia.ID_use_rt = urt;
    assign ia.ID_jump = jmp; assign ia.EX_memRead = mr; assign ia.EX_rd = rd; assign ia.EX_brTaken = br;
    assign ia.dmem_busy = busy;
    assign ib.ID_rs = rs;  assign ib.ID_rt = rt;  assign ib.ID_use_rs = urs; assign ib.ID_use_rt = urt;
    assign ib.ID_jump = jmp; assign ib.EX_memRead = mr; assign ib.EX_rd = rd; assign ib.EX_brTaken = br;
    assign ib.dmem_busy = busy;
    pipe_hazard_ctrl #(.LU_STALL(1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hz(ia));
    pipe_hazard_ctrl #(.LU_STALL(3), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz(ib));
    // model: pending bubble count per instance plus naturally wrapping counters
    int         pend_a = 0, pend_b = 0;
    logic [31:0] ms_a, mf_a;
    logic [3:0]  ms_b, mf_b;
    function automatic bit haz();
        return mr && rd != 5'd0 && ((urs && rs == rd) || (urt && rt == rd));
    endfunction
    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze}
    function automatic logic [4:0] exp_out(int pend);
        if (busy) return 5'b00001;
        if (br) return 5'b11110;
        if (pend > 0 || haz()) return 5'b00010;
        if (jmp) return 5'b11100;
        return 5'b11000;
    endfunction
    function automatic int nxt(int pend, int lu);
        if (busy) return pend;
        if (br) return 0;
        if (pend > 0) return pend - 1;
        if (haz()) return lu - 1;
        return 0;
    endfunction
    always @(posedge clk) begin : mdl
        logic [4:0] oa, ob;
        oa = exp_out(pend_a);
        ob = exp_out(pend_b);
        if (rst) begin
            pend_a <= 0; pend_b <= 0;
            ms_a <= '0; mf_a <= '0; ms_b <= '0; mf_b <= '0;
        end else begin
            pend_a <= nxt(pend_a, 1);
            pend_b <= nxt(pend_b, 3);
            ms_a <= ms_a + {31'd0, ~oa[3]};
            mf_a <= mf_a + {31'd0, oa[2]};
            ms_b <= ms_b + {3'd0, ~ob[3]};
            mf_b <= mf_b + {3'd0, ob[2]};
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin : cmp
        logic [4:0] ea, eb;
        if (chk_en) begin
            ea = exp_out(pend_a);
            eb = exp_out(pend_b);
            check("a.PCWrite", 32'(ia.PCWrite), 32'(ea[4]));
            check("a.IFIDWrite", 32'(ia.IFIDWrite), 32'(ea[3]));
            check("a.IFIDFlush", 32'(ia.IFIDFlush), 32'(ea[2]));
            check("a.IDEXFlush", 32'(ia.IDEXFlush), 32'(ea[1]));
            check("a.pipeFreeze", 32'(ia.pipeFreeze), 32'(ea[0]));
            check("a.stall_cnt", ia.stall_cnt, ms_a);
            check("a.flush_cnt", ia.flush_cnt, mf_a);
            check("b.PCWrite", 32'(ib.PCWrite), 32'(eb[4]));
            check("b.IFIDWrite", 32'(ib.IFIDWrite), 32'(eb[3]));
            check("b.IFIDFlush", 32'(ib.IFIDFlush), 32'(eb[2]));
            check("b.IDEXFlush", 32'(ib.IDEXFlush), 32'(eb[1]));
            check("b.pipeFreeze", 32'(ib.pipeFreeze), 32'(eb[0]));
            check("b.stall_cnt", 32'(ib.stall_cnt), 32'(ms_b));
            check("b.flush_cnt", 32'(ib.flush_cnt), 32'(mf_b));
        end
    end
    task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                          input logic us, input logic ut, input logic j, input logic b, input logic bz);
        mr = m; rd = d; rs = s; rt = t; urs = us; urt = ut; jmp = j; br = b; busy = bz;
        #3;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic lu_haz();
        set_in(1, 8, 8, 0, 1, 0, 0, 0, 0);
    endtask
    initial begin
        idle();
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        idle();
        check("rst.a.PCWrite", 32'(ia.PCWrite), 1);
        check("rst.a.stall_cnt", ia.stall_cnt, 0);
        check("rst.b.flush_cnt", 32'(ib.flush_cnt), 0);
        tick();
        lu_haz();
        check("lu1.a.PCWrite", 32'(ia.PCWrite), 0);
        check("lu1.a.IFIDWrite", 32'(ia.IFIDWrite), 0);
        check("lu1.a.IDEXFlush", 32'(ia.IDEXFlush), 1);
        check("lu3.b.bubble1", 32'(ib.IFIDWrite), 0);
        tick();
        idle();
        check("lu1.a.resume", 32'(ia.PCWrite), 1);
        check("lu1.a.stall_cnt", ia.stall_cnt, 1);
        check("lu3.b.bubble2", 32'(ib.IFIDWrite), 0);
        tick();
        idle();
        check("lu3.b.bubble3", 32'(ib.IFIDWrite), 0);
        check("lu3.b.stall2", 32'(ib.stall_cnt), 2);
        tick();
        idle();
        check("lu3.b.resume", 32'(ib.PCWrite), 1);
        check("lu3.b.stall3", 32'(ib.stall_cnt), 3);
        tick();
        set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
        check("rd0.a.nostall", 32'(ia.PCWrite), 1);
        check("rd0.b.nostall", 32'(ib.PCWrite), 1);
        tick();
        lu_haz();
        check("br.b.bubble1", 32'(ib.IDEXFlush), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("br.b.IFIDWrite", 32'(ib.IFIDWrite), 1);
        check("br.b.IFIDFlush", 32'(ib.IFIDFlush), 1);
        check("br.b.IDEXFlush", 32'(ib.IDEXFlush), 1);
        tick();
        idle();
        check("br.b.run", 32'(ib.PCWrite), 1);
        check("br.b.flush_cnt", 32'(ib.flush_cnt), 1);
        tick();
        lu_haz();
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
            check("frz.b.pipeFreeze", 32'(ib.pipeFreeze), 1);
            check("frz.b.IFIDWrite", 32'(ib.IFIDWrite), 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            check("frz.b.resume_bubble", 32'(ib.IDEXFlush), 1);
            check("frz.b.unfrozen", 32'(ib.pipeFreeze), 0);
            tick();
        end
        idle();
        check("frz.b.run", 32'(ib.PCWrite), 1);
        check("frz.b.stall_cnt", 32'(ib.stall_cnt), 11);
        check("frz.a.stall_cnt", ia.stall_cnt, 7);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("jbr.a.IDEXFlush", 32'(ia.IDEXFlush), 1);
        check("jbr.a.IFIDFlush", 32'(ia.IFIDFlush), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("jmp.a.IFIDFlush", 32'(ia.IFIDFlush), 1);
        check("jmp.a.IDEXFlush", 32'(ia.IDEXFlush), 0);
        check("jmp.a.PCWrite", 32'(ia.PCWrite), 1);
        tick();
        set_in(1, 5, 0, 5, 0, 1, 0, 0, 0);
        check("rt.a.IDEXFlush", 32'(ia.IDEXFlush), 1);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        idle();
        check("rstmid.b.PCWrite", 32'(ib.PCWrite), 1);
        check("rstmid.b.stall_cnt", 32'(ib.stall_cnt), 0);
        check("rstmid.b.flush_cnt", 32'(ib.flush_cnt), 0);
        check("rstmid.a.stall_cnt", ia.stall_cnt, 0);
        tick();
        set_in(1, 7, 7, 0, 0, 0, 0, 0, 0);
        check("nouse.a.PCWrite", 32'(ia.PCWrite), 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        idle();
        check("wrap.b.stall_cnt", 32'(ib.stall_cnt), 4);
        check("wrap.a.stall_cnt", ia.stall_cnt, 20);
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
